// File: rtl/simon_display_driver.sv
// Four-digit multiplexed seven-segment driver for the Simon game: mode letter,
// current pattern in hex, and a saturating BCD count of rounds played.
`timescale 1ns/1ps

module simon_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pattern_leds,
    input  logic [2:0] mode_leds,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    localparam logic [2:0] MODE_INPUT    = 3'b100;
    localparam logic [2:0] MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] MODE_REPEAT   = 3'b001;
    localparam logic [2:0] MODE_DONE     = 3'b111;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] mode_glyph(input logic [2:0] m);
        logic [6:0] g;
        case (m)
            MODE_INPUT:    g = 7'b1111001;
            MODE_PLAYBACK: g = 7'b0001100;
            MODE_REPEAT:   g = 7'b0101111;
            MODE_DONE:     g = 7'b0100001;
            default:       g = 7'b0111111;
        endcase
        return g;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic [2:0]    prev_mode_q;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic          tick;
    logic          mode_done;
    logic          play_entry;
    logic [6:0]    digit_glyph;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        presc_d       = presc_q + PW'(1);
        idx_d         = idx_q;
        ones_d        = ones_q;
        tens_d        = tens_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        seg_d         = seg_q;
        an_d          = an_q;
        digit_glyph   = SEG_OFF;

        tick       = (presc_q == PRESC_LAST);
        mode_done  = (mode_leds == MODE_DONE);
        play_entry = (mode_leds == MODE_PLAYBACK) && (prev_mode_q != MODE_PLAYBACK);

        if (tick) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end

        case (idx_q)
            2'd3:    digit_glyph = mode_glyph(mode_leds);
            2'd2:    digit_glyph = hex_glyph(pattern_leds);
            2'd1:    digit_glyph = hex_glyph(tens_q);
            default: digit_glyph = hex_glyph(ones_q);
        endcase

        // The registered count is shown, so an entry landing on a tick appears one scan later.
        if (tick) begin
            seg_d = digit_glyph;
            an_d  = (blink_phase_q && mode_done) ? AN_OFF : ~(4'b0001 << idx_q);
        end

        if (play_entry && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end

        if (!mode_done) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // NOTE: registers update with <= so every flop samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            idx_q         <= 2'd0;
            ones_q        <= 4'd0;
            tens_q        <= 4'd0;
            prev_mode_q   <= 3'b000;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            ones_q        <= ones_d;
            tens_q        <= tens_d;
            prev_mode_q   <= mode_leds;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule
